// File: rtl/intc.sv
// rtl/intc.sv - memory-mapped interrupt controller with edge capture and a held int/int_ack handshake
// Ports carry i_/o_ prefixes; this also keeps the int request clear of the SystemVerilog keyword.
module intc #(
  parameter int NSRC = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_de,
  input  logic            i_drw,
  input  logic [31:0]     i_daddr,
  input  logic [31:0]     i_din,
  output logic [31:0]     o_dout,
  input  logic [NSRC-1:0] i_irq,
  output logic            o_int,
  input  logic            i_int_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_int;
  logic              r_gie;
  logic [NSRC-1:0]   r_en;
  logic [NSRC-1:0]   r_pend;
  logic [NSRC-1:0]   r_irq_prev;

  logic              w_wr_mask;
  logic              w_wr_stat;
  logic [NSRC-1:0]   w_rise;
  logic [NSRC-1:0]   w_w1c;
  logic              w_req;
  logic              w_gie_hw_clr;
  logic [31:0]       w_mask_rd;
  logic [31:0]       w_stat_rd;
  logic              w_unused;

  assign w_wr_mask = i_de & i_drw & ~i_daddr[2];
  assign w_wr_stat = i_de & i_drw &  i_daddr[2];
  assign w_rise    = i_irq & ~r_irq_prev;
  assign w_w1c     = w_wr_stat ? i_din[NSRC:1] : '0;
  assign w_req     = r_gie & (|(r_pend & r_en));
  assign o_int     = r_int;
  assign w_unused  = ^{i_daddr[31:3], i_daddr[1:0], i_din};

  // Once ARMED, int is held independent of req so the CPU never sees it vanish.
  always_comb begin
    w_state_nxt  = r_state;
    w_gie_hw_clr = 1'b0;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_ARMED;
      S_ARMED: if (i_int_ack) begin
        w_state_nxt  = S_BUSY;
        w_gie_hw_clr = 1'b1;
      end
      S_BUSY:  if (!i_int_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_int   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_int   <= (w_state_nxt == S_ARMED);
    end
  end

  // A rising edge wins over a same-cycle W1C of the same pending bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_en       <= '0;
      r_gie      <= 1'b0;
    end else begin
      r_irq_prev <= i_irq;
      r_pend     <= (r_pend & ~w_w1c) | w_rise;
      if (w_wr_mask) r_en <= i_din[NSRC:1];
      if (w_gie_hw_clr)
        r_gie <= 1'b0;
      else if (w_wr_mask && (r_state != S_BUSY))
        r_gie <= i_din[0];
    end
  end

  always_comb begin
    w_mask_rd         = '0;
    w_mask_rd[0]      = r_gie;
    w_mask_rd[NSRC:1] = r_en;
    w_stat_rd         = '0;
    w_stat_rd[0]      = 1'b1;
    w_stat_rd[NSRC:1] = r_pend;
    o_dout            = i_daddr[2] ? w_stat_rd : w_mask_rd;
  end

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - directed self-checking bench for intc
module tb_intc;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            de;
  logic            drw;
  logic [31:0]     daddr;
  logic [31:0]     din;
  logic [31:0]     dout;
  logic [NSRC-1:0] irq;
  logic            int_o;
  logic            int_ack;

  int n_cmp = 0;
  int n_mis = 0;

  intc #(.NSRC(NSRC)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_de      (de),
    .i_drw     (drw),
    .i_daddr   (daddr),
    .i_din     (din),
    .o_dout    (dout),
    .i_irq     (irq),
    .o_int     (int_o),
    .i_int_ack (int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    daddr = addr;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic chk_int(input string tag, input logic exp);
    chk(tag, {31'd0, int_o}, {31'd0, exp});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    de = 1'b1; drw = 1'b1; daddr = addr; din = data;
    tick();
    de = 1'b0; drw = 1'b0; din = '0;
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; drw = 1'b0; daddr = '0; din = '0; irq = '0; int_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reg("reset_mask", 32'h0, 32'h0000_0000);
    chk_reg("reset_status", 32'h4, 32'h0000_0001);
    chk_int("reset_int", 1'b0);

    // Basic request and handshake
    wr(32'h0, 32'h0000_0003);
    irq = 8'h01; tick(); irq = '0;
    chk_reg("pend_src0", 32'h4, 32'h0000_0003);
    chk_int("int_not_yet", 1'b0);
    tick();
    chk_int("int_rise", 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk_int("int_held_no_ack", 1'b1);
    int_ack = 1'b1; tick();
    chk_int("int_drop_on_ack", 1'b0);
    chk_reg("gie_auto_clr", 32'h0, 32'h0000_0002);
    tick(); tick();
    chk_int("int_low_busy", 1'b0);
    int_ack = 1'b0; tick();
    wr(32'h0, 32'h0000_0003);
    chk_int("reenable_pre", 1'b0);
    tick();
    chk_int("reenable_int", 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
    wr(32'h4, 32'h0000_0002);
    chk_reg("w1c_src0", 32'h4, 32'h0000_0001);
    int_ack = 1'b1; tick();
    chk_int("spurious_ack", 1'b0);
    int_ack = 1'b0;

    // Masking
    wr(32'h0, 32'h0000_0001);
    irq = 8'h04; tick(); irq = '0;
    chk_reg("pend_masked", 32'h4, 32'h0000_0009);
    tick();
    chk_int("masked_no_int", 1'b0);
    wr(32'h0, 32'h0000_0009);
    chk_int("unmask_pre", 1'b0);
    tick();
    chk_int("unmask_int", 1'b1);
    int_ack = 1'b1; tick();
    chk_reg("mask_after_ack", 32'h0, 32'h0000_0008);
    int_ack = 1'b0; tick();
    wr(32'h4, 32'h0000_0008);
    chk_reg("w1c_src2", 32'h4, 32'h0000_0001);

    // Set beats same-cycle W1C; held irq does not re-set
    irq = 8'h02;
    wr(32'h4, 32'h0000_0004);
    chk_reg("set_wins", 32'h4, 32'h0000_0005);
    wr(32'h4, 32'h0000_0004);
    chk_reg("held_once", 32'h4, 32'h0000_0001);
    irq = '0;

    // Request held through W1C and mask clear
    wr(32'h0, 32'h0000_0005);
    irq = 8'h02; tick(); irq = '0;
    tick();
    chk_int("held_arm", 1'b1);
    wr(32'h4, 32'h0000_0004);
    wr(32'h0, 32'h0000_0000);
    chk_int("held_after_clr", 1'b1);
    chk_reg("held_status", 32'h4, 32'h0000_0001);
    tick();
    chk_int("held_still", 1'b1);
    int_ack = 1'b1; tick();
    chk_int("held_ack_int", 1'b0);
    chk_reg("held_ack_mask", 32'h0, 32'h0000_0000);
    wr(32'h0, 32'h0000_0001);
    chk_reg("busy_gie_ignored", 32'h0, 32'h0000_0000);
    int_ack = 1'b0; tick();

    // Reset mid-handshake
    wr(32'h0, 32'h0000_0003);
    irq = 8'h01; tick(); irq = '0;
    tick();
    chk_int("pre_reset_int", 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_int("midrst_int", 1'b0);
    chk_reg("midrst_mask", 32'h0, 32'h0000_0000);
    chk_reg("midrst_status", 32'h4, 32'h0000_0001);

    // Hardware GIE clear beats a simultaneous MASK write
    wr(32'h0, 32'h0000_0003);
    irq = 8'h01; tick(); irq = '0;
    tick();
    chk_int("ovr_arm", 1'b1);
    int_ack = 1'b1;
    wr(32'h0, 32'h0000_0007);
    chk_reg("ovr_mask", 32'h0, 32'h0000_0006);
    chk_int("ovr_int", 1'b0);
    wr(32'h0, 32'h0000_0005);
    chk_reg("busy_other_bits", 32'h0, 32'h0000_0004);
    int_ack = 1'b0; tick();
    wr(32'h0, 32'h0000_0003);
    chk_int("rearm_pre", 1'b0);
    tick();
    chk_int("rearm_int", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/intc.md
Name: intc

Overview:
- Memory-mapped interrupt controller; the requesting end of the CPU fetch stage's interrupt handshake (`int` / `int_ack`).
- Latches rising edges on up to NSRC peripheral request lines into a pending register and gates them with per-source masks and a global enable.
- Drives a single held interrupt request to the CPU and auto-disables the global enable once the CPU acknowledges. This guarantees no new request while a handler is being injected or run.
- Sits on the data bus alongside other memory-mapped peripherals.

Parameters:
- NSRC, 8, number of interrupt sources (1..31); source n maps to register bit n+1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- de  input  1  data bus enable, this module selected
- drw  input  1  1 = write, 0 = read (valid with de)
- daddr  input  32  byte address; only bit 2 decoded (0 = MASK, 4 = STATUS)
- din  input  32  write data
- dout  output  32  read data, combinational from daddr
- irq  input  NSRC  peripheral request lines, synchronous to clk
- int  output  1  interrupt request to CPU fetch stage
- int_ack  input  1  CPU acknowledge, high for the CPU's whole injection sequence (1-3 cycles)

Behaviour:
- Everything is synchronous, single clock domain.
- Reset: mask=0 (GIE=0), pending=0, irq_prev=0, state=IDLE, int=0. Reset has priority over every other event, including mid-handshake; int falls the next edge.

MASK register (offset 0, R/W):
- bit0 is GIE; bits NSRC:1 are source enables.
- Other bits are written-ignored and read 0.

STATUS register (offset 4, read / write-1-to-clear):
- bit0 reads 1 (controller present).
- bits NSRC:1 are pending flags.

Edge capture:
- irq_prev <= irq every cycle.
- rise = irq & ~irq_prev sets pending[n+1].
- If a rising edge and a W1C of the same bit occur in the same cycle, set wins.
- A held-high irq sets pending once only.

Request condition:
- req = GIE & |(pending[NSRC:1] & mask[NSRC:1]).

State machine (state and int are registered):
- IDLE: int=0. If req, go to ARMED next edge (int high 1 cycle after the causing edge or write).
- ARMED: int=1, held regardless of later mask, pending or GIE changes until int_ack=1. This avoids a request vanishing while the CPU samples it. On int_ack=1: GIE<=0, int<=0, go to BUSY.
- BUSY: int=0. Wait for int_ack=0, then go to IDLE.

GIE writes and the handshake:
- The hardware GIE clear in ARMED overrides a simultaneous bus write to MASK bit0. Other mask bits are still written.
- Writes to GIE are ignored while state=BUSY. All other register writes proceed normally.
- Software re-enables GIE (typically at handler exit). If pending & mask is still nonzero, int re-asserts 1 cycle after the write.
- int_ack high in IDLE (spurious): ignored, no state change.

Bus:
- Write occurs on de & drw at the clock edge.
- dout = MASK or STATUS per daddr[2], regardless of de. No side effects on read.

Arithmetic: no counters. NSRC=31 fills all 32 register bits.

Test Plan:
- Reset, then read MASK and STATUS -> dout=0x00000000 and 0x00000001; int=0.
- Write MASK=0x00000003 (GIE plus source 0), pulse irq[0] for 1 cycle -> STATUS=0x00000003, int high 2 edges after the pulse edge. Hold int_ack low 5 cycles -> int stays 1. Assert int_ack 3 cycles -> int=0 and MASK=0x00000002 the edge after ack, state returns to IDLE after ack drops.
- Masking: MASK=0x00000001, pulse irq[2] -> STATUS=0x00000009, int stays 0. Then write MASK=0x00000009 -> int=1 one cycle later.
- Write-1-to-clear versus set: same cycle as an irq[1] rising edge, write STATUS=0x00000004 -> bit2 remains 1. Next cycle write 0x00000004 -> STATUS=0x00000001.
- Held request: with int asserted, W1C its pending bit and clear MASK -> int stays 1 until int_ack. After ack, GIE=0 and int=0.
- Reset mid-handshake (state ARMED, int=1) -> next edge int=0, MASK=0, STATUS=0x00000001. A write MASK bit0=1 during BUSY -> GIE reads 0.
